// File: rtl/wordle_board_ctrl.sv
// Wordle guess-entry and two-pass scoring engine with a combinational board read port.
// Optional macro CURSOR_WRAP_EN: the cursor wraps at the row edges instead of saturating.
module wordle_board_ctrl #(
    parameter int WORD_LEN = 5,
    parameter int NUM_ROWS = 6,
    parameter int LETTER_W = 5
) (
    input  logic                         i_clk,
    input  logic                         i_clr,
    input  logic                         i_new_game,
    input  logic [WORD_LEN*LETTER_W-1:0] i_target,
    input  logic                         i_btnu,
    input  logic                         i_btnd,
    input  logic                         i_btnl,
    input  logic                         i_btnr,
    input  logic                         i_btns,
    input  logic [2:0]                   i_rd_row,
    input  logic [2:0]                   i_rd_col,
    output logic [LETTER_W-1:0]          o_rd_letter,
    output logic [1:0]                   o_rd_score,
    output logic [2:0]                   o_cur_row,
    output logic [2:0]                   o_cur_col,
    output logic                         o_busy,
    output logic                         o_reject,
    output logic                         o_game_won,
    output logic                         o_game_lost
);

    typedef enum logic [2:0] {IDLE, ENTRY, SCORE1, SCORE2, CHECK, WON, LOST} state_t;

    localparam logic [2:0]          LAST_COL = 3'(WORD_LEN - 1);
    localparam logic [2:0]          LAST_ROW = 3'(NUM_ROWS - 1);
    localparam logic [3:0]          ROWS4    = 4'(NUM_ROWS);
    localparam logic [3:0]          COLS4    = 4'(WORD_LEN);
    localparam logic [LETTER_W-1:0] LTR_A    = LETTER_W'(1);
    localparam logic [LETTER_W-1:0] LTR_Z    = LETTER_W'(26);

`ifdef CURSOR_WRAP_EN
    localparam logic [2:0] COL_AFTER_LEFT_EDGE  = LAST_COL;
    localparam logic [2:0] COL_AFTER_RIGHT_EDGE = 3'd0;
`else
    localparam logic [2:0] COL_AFTER_LEFT_EDGE  = 3'd0;
    localparam logic [2:0] COL_AFTER_RIGHT_EDGE = LAST_COL;
`endif

    state_t                r_state;
    logic [LETTER_W-1:0]   r_letters [NUM_ROWS][WORD_LEN];
    logic [1:0]            r_scores  [NUM_ROWS][WORD_LEN];
    logic [LETTER_W-1:0]   r_target  [WORD_LEN];
    logic [WORD_LEN-1:0]   r_used;
    logic [2:0]            r_idx;
    logic [2:0]            r_curRow;
    logic [2:0]            r_curCol;
    logic                  r_busy;
    logic                  r_reject;
    logic                  r_won;
    logic                  r_lost;

    logic                  w_rowFull;
    logic                  w_allCorrect;
    logic                  w_found;
    logic [2:0]            w_foundJ;
    logic [LETTER_W-1:0]   w_guessI;
    logic [LETTER_W-1:0]   w_curLetter;

    function automatic logic [LETTER_W-1:0] letterUp(input logic [LETTER_W-1:0] l);
        if (l == '0 || l >= LTR_Z) return LTR_A;
        return l + LTR_A;
    endfunction

    function automatic logic [LETTER_W-1:0] letterDown(input logic [LETTER_W-1:0] l);
        if (l <= LTR_A || l > LTR_Z) return LTR_Z;
        return l - LTR_A;
    endfunction

    assign w_guessI    = r_letters[r_curRow][r_idx];
    assign w_curLetter = r_letters[r_curRow][r_curCol];

    // Descending search so the lowest matching unused target position wins.
    always_comb begin
        w_rowFull    = 1'b1;
        w_allCorrect = 1'b1;
        w_found      = 1'b0;
        w_foundJ     = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (r_letters[r_curRow][i] == '0) w_rowFull = 1'b0;
            if (r_scores[r_curRow][i] != 2'd3) w_allCorrect = 1'b0;
        end
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!r_used[j] && r_target[j] == w_guessI) begin
                w_found  = 1'b1;
                w_foundJ = 3'(j);
            end
        end
    end

    always_comb begin
        o_rd_letter = '0;
        o_rd_score  = '0;
        if ({1'b0, i_rd_row} < ROWS4 && {1'b0, i_rd_col} < COLS4) begin
            o_rd_letter = r_letters[i_rd_row][i_rd_col];
            o_rd_score  = r_scores[i_rd_row][i_rd_col];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr || i_new_game) begin
            r_state  <= i_clr ? IDLE : ENTRY;
            r_curRow <= '0;
            r_curCol <= '0;
            r_idx    <= '0;
            r_used   <= '0;
            r_busy   <= 1'b0;
            r_reject <= 1'b0;
            r_won    <= 1'b0;
            r_lost   <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < WORD_LEN; c++) begin
                    r_letters[r][c] <= '0;
                    r_scores[r][c]  <= '0;
                end
            end
            for (int c = 0; c < WORD_LEN; c++) begin
                r_target[c] <= i_clr ? '0 : i_target[c*LETTER_W +: LETTER_W];
            end
        end else begin
            r_reject <= 1'b0;
            case (r_state)
                ENTRY: begin
                    if (i_btns) begin
                        if (w_rowFull) begin
                            r_state <= SCORE1;
                            r_busy  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end else if (i_btnu) begin
                        r_letters[r_curRow][r_curCol] <= letterUp(w_curLetter);
                    end else if (i_btnd) begin
                        r_letters[r_curRow][r_curCol] <= letterDown(w_curLetter);
                    end else if (i_btnl) begin
                        r_curCol <= (r_curCol == 3'd0) ? COL_AFTER_LEFT_EDGE : r_curCol - 3'd1;
                    end else if (i_btnr) begin
                        r_curCol <= (r_curCol == LAST_COL) ? COL_AFTER_RIGHT_EDGE : r_curCol + 3'd1;
                    end
                end
                SCORE1: begin
                    if (w_guessI == r_target[r_idx]) begin
                        r_scores[r_curRow][r_idx] <= 2'd3;
                        r_used[r_idx]             <= 1'b1;
                    end else begin
                        r_used[r_idx] <= 1'b0;
                    end
                    if (r_idx == LAST_COL) begin
                        r_idx   <= '0;
                        r_state <= SCORE2;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                SCORE2: begin
                    if (r_scores[r_curRow][r_idx] == 2'd0) begin
                        if (w_found) begin
                            r_scores[r_curRow][r_idx] <= 2'd2;
                            r_used[w_foundJ]          <= 1'b1;
                        end else begin
                            r_scores[r_curRow][r_idx] <= 2'd1;
                        end
                    end
                    if (r_idx == LAST_COL) begin
                        r_idx   <= '0;
                        r_state <= CHECK;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                CHECK: begin
                    r_busy <= 1'b0;
                    if (w_allCorrect) begin
                        r_state <= WON;
                        r_won   <= 1'b1;
                    end else if (r_curRow == LAST_ROW) begin
                        r_state <= LOST;
                        r_lost  <= 1'b1;
                    end else begin
                        r_curRow <= r_curRow + 3'd1;
                        r_curCol <= '0;
                        r_state  <= ENTRY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cur_row   = r_curRow;
    assign o_cur_col   = r_curCol;
    assign o_busy      = r_busy;
    assign o_reject    = r_reject;
    assign o_game_won  = r_won;
    assign o_game_lost = r_lost;

endmodule

// File: tb/tb_wordle_board_ctrl.sv
// Randomised self-checking bench for wordle_board_ctrl against a word-level game model.
// Define CURSOR_WRAP_EN here as well when building the wrapping variant.
module tb_wordle_board_ctrl;

    localparam int WL = 5;
    localparam int NR = 6;
    localparam int LW = 5;
    localparam int PH_IDLE  = 0;
    localparam int PH_ENTRY = 1;
    localparam int PH_WON   = 2;
    localparam int PH_LOST  = 3;

    typedef int word_t [WL];

    logic             clk = 1'b0;
    logic             clr, newGame;
    logic [WL*LW-1:0] target;
    logic             btnu, btnd, btnl, btnr, btns;
    logic [2:0]       rdRow, rdCol;
    logic [LW-1:0]    rdLetter;
    logic [1:0]       rdScore;
    logic [2:0]       curRow, curCol;
    logic             busy, reject, won, lost;

    int testCount = 0;
    int failCount = 0;

    int mLetters [NR][WL];
    int mScores  [NR][WL];
    int mTarget  [WL];
    int mRow, mCol, mPhase;

    always #5 clk = ~clk;

    wordle_board_ctrl #(.WORD_LEN(WL), .NUM_ROWS(NR), .LETTER_W(LW)) dut (
        .i_clk(clk), .i_clr(clr), .i_new_game(newGame), .i_target(target),
        .i_btnu(btnu), .i_btnd(btnd), .i_btnl(btnl), .i_btnr(btnr), .i_btns(btns),
        .i_rd_row(rdRow), .i_rd_col(rdCol), .o_rd_letter(rdLetter), .o_rd_score(rdScore),
        .o_cur_row(curRow), .o_cur_col(curCol), .o_busy(busy), .o_reject(reject),
        .o_game_won(won), .o_game_lost(lost)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit coin();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic word_t toWord(input string s);
        word_t w;
        for (int i = 0; i < WL; i++) w[i] = int'(s[i]) - 64;
        return w;
    endfunction

    function automatic word_t randWord(input int alphabet);
        word_t w;
        for (int i = 0; i < WL; i++) w[i] = int'($urandom_range(1, alphabet));
        return w;
    endfunction

    // Wordle rule: exact hits first, then each leftover target letter credits one guess letter.
    function automatic void scoreWord(input word_t g, input word_t t, output word_t sc);
        int cnt [27];
        for (int k = 0; k < 27; k++) cnt[k] = 0;
        for (int i = 0; i < WL; i++) begin
            if (g[i] == t[i]) sc[i] = 3;
            else begin
                sc[i] = 0;
                cnt[t[i]]++;
            end
        end
        for (int i = 0; i < WL; i++) begin
            if (sc[i] != 3) begin
                if (cnt[g[i]] > 0) begin
                    sc[i] = 2;
                    cnt[g[i]]--;
                end else sc[i] = 1;
            end
        end
    endfunction

    task automatic modelClear(input int phase);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < WL; c++) begin
                mLetters[r][c] = 0;
                mScores[r][c]  = 0;
            end
        mRow   = 0;
        mCol   = 0;
        mPhase = phase;
    endtask

    task automatic readCell(input int r, input int c, output logic [31:0] l, output logic [31:0] s);
        rdRow = 3'(r);
        rdCol = 3'(c);
        #1;
        l = 32'(rdLetter);
        s = 32'(rdScore);
    endtask

    task automatic checkBoard();
        logic [31:0] l, s;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                readCell(r, c, l, s);
                checkOutput($sformatf("letter[%0d][%0d]", r, c), l,
                            (r < NR && c < WL) ? 32'(mLetters[r][c]) : 32'd0);
                checkOutput($sformatf("score[%0d][%0d]", r, c), s,
                            (r < NR && c < WL) ? 32'(mScores[r][c]) : 32'd0);
            end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_row"},  32'(curRow), 32'(mRow));
        checkOutput({tag, "_col"},  32'(curCol), 32'(mCol));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_won"},  32'(won),  32'(mPhase == PH_WON));
        checkOutput({tag, "_lost"}, 32'(lost), 32'(mPhase == PH_LOST));
    endtask

    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r, input bit s);
        @(negedge clk);
        btnu = u; btnd = d; btnl = l; btnr = r; btns = s;
        @(negedge clk);
        btnu = 0; btnd = 0; btnl = 0; btnr = 0; btns = 0;
    endtask

    task automatic scoreAndWait();
        word_t g, sc;
        for (int i = 0; i < WL; i++) g[i] = mLetters[mRow][i];
        scoreWord(g, mTarget, sc);
        checkOutput("busy_c1", 32'(busy), 32'd1);
        for (int k = 2; k <= 2 * WL + 1; k++) begin
            btnu = coin(); btnd = coin(); btnl = coin(); btnr = coin(); btns = coin();
            @(negedge clk);
            checkOutput($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
            checkOutput("reject_busy", 32'(reject), 32'd0);
        end
        btnu = 0; btnd = 0; btnl = 0; btnr = 0; btns = 0;
        @(negedge clk);
        for (int i = 0; i < WL; i++) mScores[mRow][i] = sc[i];
        if (sc[0] == 3 && sc[1] == 3 && sc[2] == 3 && sc[3] == 3 && sc[4] == 3) mPhase = PH_WON;
        else if (mRow == NR - 1) mPhase = PH_LOST;
        else begin
            mRow++;
            mCol = 0;
        end
        checkStatus("after_check");
        checkBoard();
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r, input bit s);
        bit submit = 0;
        bit expRej = 0;
        logic [31:0] gotL, gotS;
        if (mPhase == PH_ENTRY) begin
            if (s) begin
                submit = 1;
                for (int i = 0; i < WL; i++) if (mLetters[mRow][i] == 0) submit = 0;
                expRej = !submit;
            end else if (u) begin
                mLetters[mRow][mCol] = (mLetters[mRow][mCol] == 0 || mLetters[mRow][mCol] >= 26) ? 1 : mLetters[mRow][mCol] + 1;
            end else if (d) begin
                mLetters[mRow][mCol] = (mLetters[mRow][mCol] <= 1) ? 26 : mLetters[mRow][mCol] - 1;
            end else if (l) begin
`ifdef CURSOR_WRAP_EN
                mCol = (mCol == 0) ? WL - 1 : mCol - 1;
`else
                mCol = (mCol == 0) ? 0 : mCol - 1;
`endif
            end else if (r) begin
`ifdef CURSOR_WRAP_EN
                mCol = (mCol == WL - 1) ? 0 : mCol + 1;
`else
                mCol = (mCol == WL - 1) ? WL - 1 : mCol + 1;
`endif
            end
        end
        applyStimulus(u, d, l, r, s);
        if (submit) scoreAndWait();
        else begin
            checkOutput("reject", 32'(reject), 32'(expRej));
            checkOutput("cur_col", 32'(curCol), 32'(mCol));
            checkOutput("cur_row", 32'(curRow), 32'(mRow));
            readCell(mRow, mCol, gotL, gotS);
            checkOutput("cursor_letter", gotL, 32'(mLetters[mRow][mCol]));
        end
    endtask

    task automatic enterLetter(input int col, input int v);
        int cur, upSteps, downSteps;
        for (int n = 0; n < 16 && mCol != col; n++) begin
            if (mCol < col) press(0, 0, 0, 1, 0);
            else press(0, 0, 1, coin(), 0);
        end
        for (int n = 0; n < 40; n++) begin
            cur = mLetters[mRow][col];
            if (cur == v) break;
            upSteps   = (cur == 0) ? v : (v - cur + 26) % 26;
            downSteps = (cur == 0) ? 27 - v : (cur - v + 26) % 26;
            if (upSteps <= downSteps) press(1, coin(), coin(), coin(), 0);
            else press(0, 1, coin(), coin(), 0);
        end
    endtask

    task automatic enterWord(input word_t w);
        for (int c = 0; c < WL; c++) enterLetter(c, w[c]);
    endtask

    task automatic startGame(input word_t t);
        @(negedge clk);
        newGame = 1;
        for (int i = 0; i < WL; i++) target[i*LW +: LW] = LW'(t[i]);
        @(negedge clk);
        newGame = 0;
        modelClear(PH_ENTRY);
        mTarget = t;
        checkStatus("new_game");
    endtask

    initial begin
        word_t w, t, expSc;
        logic [31:0] gotL, gotS;
        clr = 0; newGame = 0; target = '0;
        btnu = 0; btnd = 0; btnl = 0; btnr = 0; btns = 0;
        rdRow = 0; rdCol = 0;

        @(negedge clk); clr = 1;
        @(negedge clk); @(negedge clk); clr = 0;
        modelClear(PH_IDLE);
        checkStatus("reset");
        checkBoard();
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 1);

        // Exact guess wins on the first row.
        startGame(toWord("CRANE"));
        enterWord(toWord("CRANE"));
        press(0, 0, 0, 0, 1);
        checkOutput("crane_won", 32'(won), 32'd1);
        press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 1);
        checkStatus("won_hold");

        startGame(toWord("APPLE"));
        enterWord(toWord("PAPER"));
        press(0, 0, 0, 0, 1);
        expSc = '{2, 2, 3, 2, 1};
        for (int c = 0; c < WL; c++) begin
            readCell(0, c, gotL, gotS);
            checkOutput($sformatf("paper_score%0d", c), gotS, 32'(expSc[c]));
        end

        startGame(toWord("ABBEY"));
        enterWord(toWord("BOBBY"));
        press(0, 0, 0, 0, 1);
        expSc = '{2, 1, 3, 1, 3};
        for (int c = 0; c < WL; c++) begin
            readCell(0, c, gotL, gotS);
            checkOutput($sformatf("bobby_score%0d", c), gotS, 32'(expSc[c]));
        end

        // Blank letter at column 3 makes the submit bounce.
        startGame(randWord(26));
        w = randWord(26);
        enterLetter(0, w[0]); enterLetter(1, w[1]); enterLetter(2, w[2]); enterLetter(4, w[4]);
        press(0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("reject_one_cycle", 32'(reject), 32'd0);
        checkStatus("after_reject");
        checkBoard();

        // Six misses end the game.
        t = randWord(26);
        startGame(t);
        for (int r = 0; r < NR; r++) begin
            w = randWord(26);
            if (w == t) w[0] = (t[0] % 26) + 1;
            enterWord(w);
            press(0, 0, 0, 0, 1);
        end
        checkOutput("lost_flag", 32'(lost), 32'd1);
        checkOutput("lost_row", 32'(curRow), 32'(NR - 1));
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        startGame(randWord(26));
        checkBoard();

        // Cursor edge behaviour and same-cycle button priority.
        for (int n = 0; n < WL - 1; n++) press(0, 0, 0, 1, 0);
        press(0, 0, 0, 1, 0);
`ifdef CURSOR_WRAP_EN
        checkOutput("edge_right", 32'(curCol), 32'd0);
`else
        checkOutput("edge_right", 32'(curCol), 32'(WL - 1));
`endif
        press(0, 1, 0, 0, 0);
        readCell(mRow, mCol, gotL, gotS);
        checkOutput("blank_down_z", gotL, 32'd26);
        press(1, 0, 1, 0, 0);
        readCell(mRow, mCol, gotL, gotS);
        checkOutput("up_beats_left", gotL, 32'd1);

        // Random games, small alphabets on odd games to force duplicate letters.
        for (int g = 0; g < 4; g++) begin
            t = randWord((g % 2) ? 4 : 26);
            startGame(t);
            for (int r = 0; r < NR && mPhase == PH_ENTRY; r++) begin
                w = ($urandom_range(0, 3) == 0) ? t : randWord((g % 2) ? 4 : 26);
                enterWord(w);
                press(0, 0, 0, 0, 1);
            end
        end

        // clr in the middle of scoring.
        startGame(randWord(26));
        enterWord(randWord(26));
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("busy_before_clr", 32'(busy), 32'd1);
        clr = 1;
        @(negedge clk);
        clr = 0;
        modelClear(PH_IDLE);
        checkStatus("clr_scoring");
        checkBoard();

        // clr and new_game together: clr wins.
        startGame(randWord(26));
        press(1, 0, 0, 0, 0);
        @(negedge clk);
        clr = 1; newGame = 1;
        @(negedge clk);
        clr = 0; newGame = 0;
        modelClear(PH_IDLE);
        checkStatus("clr_beats_new");
        press(1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
